lsu_bus_master: RTL and testbench

//  M-stage load/store initiator. Accepts one pipeline load/store per op, checks alignment
//  and range, lane-aligns store data and byte enables, and drives a req/gnt/rvalid word bus.

---
 rtl/lsu_bus_master.sv | 237 +++++++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// -----------------------------------------------------------------------------
// lsu_bus_master
//   M-stage load/store initiator. Takes one load or store from the pipeline,
//   checks alignment and address range, lane-aligns store data and byte
//   enables, and runs a single transfer on a req/gnt/rvalid word bus. Load data
//   is returned sign- or zero-extended. The pipeline is stalled until the
//   access completes or is aborted by the timeout.
//
// Ports
//   clk, reset            clock (rising edge), synchronous active-high reset
//   op_valid              M-stage holds a memory op (stable while stall=1)
//   op_store[1:0]         01 sb, 10 sh, 11 sw, 00 none
//   op_load[2:0]          001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, else none
//   addr, wdata           byte address, right-justified store data
//   stall                 freeze the pipeline (combinational)
//   rdata, rdata_valid    extended load result, valid for one cycle
//   adel, ades            load/store address error (combinational)
//   bus_err               one-cycle pulse on timeout abort
//   bus_req/we/addr/be/wdata  request side of the word bus
//   bus_gnt, bus_rvalid, bus_rdata  response side of the word bus
// -----------------------------------------------------------------------------
module lsu_bus_master #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] DM_TOP      = 32'h0000_2FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_store,
    input  logic [2:0]  op_load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The counter holds the number of REQ/RESP cycles already spent; the
    // transfer is abandoned during the TIMEOUT_CYC-th such cycle.
    localparam int unsigned    TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT_CYC - 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tcnt;
    logic          last_cyc;
    logic          abort;
    logic          capture;

    // Op decode
    logic        is_sb;
    logic        is_sh;
    logic        is_sw;
    logic        do_store;
    logic        do_load;
    logic        is_lh_any;
    logic        is_lw;
    logic        range_err;
    logic        st_exc;
    logic        ld_exc;
    logic        op_go;
    logic [3:0]  be_nxt;
    logic [31:0] wd_nxt;

    // Load kind and lane remembered from the accepted op
    logic [2:0]  kind_p1;
    logic [1:0]  lane_p1;

    // Extract the addressed byte/halfword and extend it to 32 bits.
    function automatic logic [31:0] ext_load(input logic [31:0] word,
                                             input logic [2:0]  kind,
                                             input logic [1:0]  lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = $signed(word[{lane, 3'b000} +: 8]);
        h = $signed(word[{lane[1], 4'b0000} +: 16]);
        case (kind)
            3'd1:    res = {{24{b[7]}}, b};
            3'd2:    res = {24'h000000, b};
            3'd3:    res = {{16{h[15]}}, h};
            3'd4:    res = {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Store wins when both store and load codes are present.
    assign is_sb     = (op_store == 2'b01);
    assign is_sh     = (op_store == 2'b10);
    assign is_sw     = (op_store == 2'b11);
    assign do_store  = (op_store != 2'b00);
    assign do_load   = !do_store && (op_load >= 3'd1) && (op_load <= 3'd5);
    assign is_lh_any = (op_load == 3'd3) || (op_load == 3'd4);
    assign is_lw     = (op_load == 3'd5);
    assign range_err = (addr > DM_TOP);

    assign st_exc = do_store && ((is_sh && addr[0]) ||
                                 (is_sw && (addr[1:0] != 2'b00)) ||
                                 range_err);
    assign ld_exc = do_load  && ((is_lh_any && addr[0]) ||
                                 (is_lw && (addr[1:0] != 2'b00)) ||
                                 range_err);

    assign op_go = op_valid && (do_store || do_load) && !st_exc && !ld_exc;

    // Byte lanes and lane-replicated store data; loads fetch the whole word.
    always_comb begin
        be_nxt = 4'b1111;
        wd_nxt = wdata;
        if (is_sb) begin
            be_nxt = 4'b0001 << addr[1:0];
            wd_nxt = {4{wdata[7:0]}};
        end else if (is_sh) begin
            be_nxt = addr[1] ? 4'b1100 : 4'b0011;
            wd_nxt = {2{wdata[15:0]}};
        end
    end

    assign last_cyc = (tcnt == TLAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A store grant or a read response in the final
    // allowed cycle still completes normally; a load grant in that cycle
    // leaves no time for the response and aborts.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_go) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt && bus_we) begin
                    state_nxt = S_DONE;
                end else if (last_cyc) begin
                    state_nxt = S_DONE;
                    abort     = 1'b1;
                end else if (bus_gnt) begin
                    // rvalid alongside gnt is not a response; wait in RESP
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus_rvalid) begin
                    state_nxt = S_DONE;
                    capture   = 1'b1;
                end else if (last_cyc) begin
                    state_nxt = S_DONE;
                    abort     = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus_req = (state == S_REQ);
        stall   = op_go && (state != S_DONE);
        adel    = op_valid && (state == S_IDLE) && ld_exc;
        ades    = op_valid && (state == S_IDLE) && st_exc;
    end

    // Request fields latch on acceptance and hold through the transfer;
    // completion status is registered into DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            kind_p1     <= '0;
            lane_p1     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            tcnt        <= '0;
        end else begin
            rdata_valid <= capture;
            bus_err     <= abort;
            if ((state == S_IDLE) && op_go) begin
                bus_we    <= do_store;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= be_nxt;
                bus_wdata <= wd_nxt;
                kind_p1   <= do_store ? 3'd0 : op_load;
                lane_p1   <= addr[1:0];
            end
            if (capture) begin
                rdata <= ext_load(bus_rdata, kind_p1, lane_p1);
            end else if (abort) begin
                rdata <= '0;
            end
            if ((state == S_REQ) || (state == S_RESP)) begin
                tcnt <= tcnt + TW'(1);
            end else begin
                tcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_bus_master
//   Directed bench for lsu_bus_master. Each transaction is expanded into a
//   per-cycle list of driven inputs and expected outputs from the access
//   rules (size, alignment, range, lane arithmetic, timeout budget); a single
//   player process applies one entry per cycle and compares the outputs.
//   Observed values are also captured and pinned against literal results.
// -----------------------------------------------------------------------------
module tb_lsu_bus_master;

    localparam int          TO  = 4;
    localparam logic [31:0] TOP = 32'h0000_2FFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op_store = 2'b00;
    logic [2:0]  op_load = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        adel;
    logic        ades;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;

    always #5 clk = ~clk;

    lsu_bus_master #(.TIMEOUT_CYC(TO), .DM_TOP(TOP)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_store(op_store),
        .op_load(op_load), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .adel(adel), .ades(ades),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        rst, ov, gnt, rv, clr;
        logic [1:0]  st;
        logic [2:0]  ld;
        logic [31:0] a, wd, rw;
        logic        chk_all, chk_bus, chk_wd, chk_rd;
        logic        e_stall, e_req, e_we, e_rdv, e_adel, e_ades, e_err;
        logic [31:0] e_baddr, e_bwd, e_rd;
        logic [3:0]  e_be;
    } cyc_t;

    cyc_t q[$];
    cyc_t cur;
    bit   have;

    int n_vec = 0;
    int n_fail = 0;

    logic [31:0] cap_baddr, cap_bwd, cap_rd, cap_rd_err;
    logic [3:0]  cap_be;
    logic        cap_we;
    int          stall_cnt, err_cnt, rdv_cnt, adel_cnt, ades_cnt, req_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [1:0] st, input logic [2:0] ld);
        if (st == 2'b01) return 1;
        if (st == 2'b10) return 2;
        if (st == 2'b11) return 4;
        case (ld)
            3'd1, 3'd2: return 1;
            3'd3, 3'd4: return 2;
            3'd5:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] st, input logic [31:0] a);
        if (st == 2'b01) return 4'(32'd1 << (a % 32'd4));
        if (st == 2'b10) return ((a % 32'd4) >= 32'd2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] st, input logic [31:0] wd);
        if (st == 2'b01) return (wd & 32'h000000FF) * 32'h01010101;
        if (st == 2'b10) return (wd & 32'h0000FFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] ld, input logic [31:0] a,
                                          input logic [31:0] w);
        longint v;
        case (ld)
            3'd1, 3'd2: begin
                v = longint'((w >> (32'd8 * (a % 32'd4))) & 32'h000000FF);
                if (ld == 3'd1 && v >= 128) v = v - 256;
            end
            3'd3, 3'd4: begin
                v = longint'((w >> (32'd16 * ((a / 32'd2) % 32'd2))) & 32'h0000FFFF);
                if (ld == 3'd3 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    // Expand one op into its cycle-by-cycle timeline. gd/rd are the numbers
    // of idle cycles before gnt/rvalid; norv withholds the response; rvgnt
    // also raises rvalid in the grant cycle.
    task automatic add_txn(input logic [1:0] st, input logic [2:0] ld,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gd, input int rd, input logic [31:0] rw,
                           input bit norv, input bit rvgnt);
        cyc_t c, r;
        bit   is_st, is_ld, abort;
        int   sz, n, k;
        c = '{default: '0};
        c.ov = 1'b1; c.st = st; c.ld = ld; c.a = a; c.wd = wd; c.rw = rw; c.clr = 1'b1;
        is_st = (st != 2'b00);
        is_ld = !is_st && (ld >= 3'd1) && (ld <= 3'd5);
        if (!is_st && !is_ld) begin
            q.push_back(c);
            return;
        end
        sz = acc_size(st, ld);
        if (((a % sz) != 0) || (a > TOP)) begin
            c.e_adel = is_ld;
            c.e_ades = is_st;
            q.push_back(c);
            return;
        end
        r = c; r.e_stall = 1'b1; q.push_back(r);
        c.clr = 1'b0;
        c.e_we = is_st;
        c.e_baddr = a - (a % 32'd4);
        c.e_be = is_st ? m_be(st, a) : 4'hF;
        c.e_bwd = m_wd(st, wd);
        n = 0; abort = 1'b0; k = 0;
        while (1) begin
            r = c; r.e_stall = 1'b1; r.e_req = 1'b1; r.chk_bus = 1'b1; r.chk_wd = is_st;
            r.gnt = (k == gd); r.rv = rvgnt && (k == gd); r.rw = ~rw;
            q.push_back(r);
            n++;
            if (k == gd) begin
                if (!is_st && n == TO) abort = 1'b1;
                break;
            end
            if (n == TO) begin
                abort = 1'b1;
                break;
            end
            k++;
        end
        if (is_ld && !abort) begin
            k = 0;
            while (1) begin
                r = c; r.e_stall = 1'b1; r.rv = !norv && (k == rd);
                q.push_back(r);
                n++;
                if (r.rv) break;
                if (n == TO) begin
                    abort = 1'b1;
                    break;
                end
                k++;
            end
        end
        r = c;
        r.e_rdv = is_ld && !abort;
        r.chk_rd = is_ld || abort;
        r.e_rd = abort ? 32'h0 : m_ext(ld, a, rw);
        r.e_err = abort;
        q.push_back(r);
    endtask

    task automatic add_idle(input logic rst, input logic rv, input logic chk_all);
        cyc_t c;
        c = '{default: '0};
        c.rst = rst; c.rv = rv; c.rw = 32'hC0FFEE00; c.chk_all = chk_all; c.chk_rd = chk_all;
        q.push_back(c);
    endtask

    task automatic drain();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            #1;
            g++;
        end while (q.size() != 0 && g < 500);
        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d cycles left, expected 0", q.size());
            q.delete();
        end
    endtask

    // ---------------- player / compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                cur = q.pop_front();
                have = 1'b1;
                reset = cur.rst; op_valid = cur.ov; op_store = cur.st; op_load = cur.ld;
                addr = cur.a; wdata = cur.wd; bus_gnt = cur.gnt; bus_rvalid = cur.rv;
                bus_rdata = cur.rw;
            end else begin
                have = 1'b0;
                reset = 1'b0; op_valid = 1'b0; op_store = 2'b00; op_load = 3'b000;
                bus_gnt = 1'b0; bus_rvalid = 1'b0;
            end
            @(negedge clk);
            if (have) begin
                check("stall", stall, cur.e_stall);
                check("bus_req", bus_req, cur.e_req);
                check("adel", adel, cur.e_adel);
                check("ades", ades, cur.e_ades);
                check("rdata_valid", rdata_valid, cur.e_rdv);
                check("bus_err", bus_err, cur.e_err);
                if (cur.chk_bus || cur.chk_all) begin
                    check("bus_we", bus_we, cur.e_we);
                    check("bus_addr", bus_addr, cur.e_baddr);
                    check("bus_be", bus_be, cur.e_be);
                end
                if (cur.chk_wd || cur.chk_all) check("bus_wdata", bus_wdata, cur.e_bwd);
                if (cur.chk_rd || cur.chk_all) check("rdata", rdata, cur.e_rd);
                if (cur.clr) begin
                    stall_cnt = 0; err_cnt = 0; rdv_cnt = 0; adel_cnt = 0;
                    ades_cnt = 0; req_cnt = 0;
                    cap_baddr = '0; cap_bwd = '0; cap_be = '0; cap_we = 1'b0;
                    cap_rd = '0; cap_rd_err = 32'hFFFFFFFF;
                end
                if (bus_req) begin
                    req_cnt++;
                    cap_baddr = bus_addr; cap_bwd = bus_wdata; cap_be = bus_be; cap_we = bus_we;
                end
                if (stall) stall_cnt++;
                if (adel) adel_cnt++;
                if (ades) ades_cnt++;
                if (rdata_valid) begin
                    rdv_cnt++;
                    cap_rd = rdata;
                end
                if (bus_err) begin
                    err_cnt++;
                    cap_rd_err = rdata;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        cyc_t c, r;
        add_idle(1'b1, 1'b0, 1'b1);
        add_idle(1'b1, 1'b0, 1'b1);
        add_idle(1'b0, 1'b0, 1'b0);
        drain();

        // sw, grant in the second request cycle
        add_txn(2'b11, 3'd0, 32'h10, 32'h12345678, 1, 0, 32'h0, 1'b0, 1'b0);
        drain();
        check("sw_addr", cap_baddr, 32'h10);
        check("sw_be", 32'(cap_be), 32'hF);
        check("sw_we", 32'(cap_we), 32'h1);
        check("sw_wdata", cap_bwd, 32'h12345678);
        check("sw_stall_cycles", stall_cnt, 3);

        add_txn(2'b01, 3'd0, 32'h13, 32'h000000AB, 0, 0, 32'h0, 1'b0, 1'b0);
        drain();
        check("sb_addr", cap_baddr, 32'h10);
        check("sb_be", 32'(cap_be), 32'h8);
        check("sb_wdata", cap_bwd, 32'hABABABAB);
        check("sb_stall_cycles", stall_cnt, 2);

        add_txn(2'b10, 3'd0, 32'h12, 32'h1234BEEF, 0, 0, 32'h0, 1'b0, 1'b0);
        drain();
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_bwd, 32'hBEEFBEEF);
        add_txn(2'b10, 3'd0, 32'h10, 32'h0000CAFE, 0, 0, 32'h0, 1'b0, 1'b0);
        drain();

        // loads
        add_txn(2'b00, 3'd1, 32'h12, 32'h0, 0, 0, 32'h0080FF00, 1'b0, 1'b0);
        drain();
        check("lb_ff00_rdata", cap_rd, 32'hFFFFFF80);
        check("lb_rdv_count", rdv_cnt, 1);
        check("lb_we", 32'(cap_we), 32'h0);
        add_txn(2'b00, 3'd2, 32'h12, 32'h0, 0, 1, 32'h00800000, 1'b0, 1'b0);
        drain();
        check("lbu_rdata", cap_rd, 32'h00000080);
        add_txn(2'b00, 3'd1, 32'h12, 32'h0, 0, 0, 32'h00800000, 1'b0, 1'b0);
        drain();
        check("lb_rdata", cap_rd, 32'hFFFFFF80);
        add_txn(2'b00, 3'd1, 32'h2FFF, 32'h0, 0, 0, 32'h7F000000, 1'b0, 1'b0);
        drain();
        check("lb_top_rdata", cap_rd, 32'h0000007F);
        add_txn(2'b00, 3'd3, 32'h2, 32'h0, 1, 0, 32'h80010000, 1'b0, 1'b0);
        drain();
        check("lh_rdata", cap_rd, 32'hFFFF8001);
        add_txn(2'b00, 3'd4, 32'h2, 32'h0, 0, 0, 32'h80010000, 1'b0, 1'b0);
        drain();
        check("lhu_rdata", cap_rd, 32'h00008001);
        add_txn(2'b00, 3'd3, 32'h0, 32'h0, 0, 0, 32'h1234F00D, 1'b0, 1'b0);
        add_txn(2'b00, 3'd5, 32'h8, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        drain();
        check("lw_rdata", cap_rd, 32'hDEADBEEF);

        // address errors
        add_txn(2'b00, 3'd5, 32'h6, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        drain();
        check("lw_mis_adel", adel_cnt, 1);
        check("lw_mis_stall", stall_cnt, 0);
        check("lw_mis_req", req_cnt, 0);
        add_txn(2'b10, 3'd0, 32'h11, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        drain();
        check("sh_mis_ades", ades_cnt, 1);
        add_txn(2'b11, 3'd0, 32'h3000, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        add_txn(2'b00, 3'd1, 32'h3000, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        add_txn(2'b11, 3'd0, 32'h2FFC, 32'h89ABCDEF, 0, 0, 32'h0, 1'b0, 1'b0);
        drain();

        // rvalid together with gnt must not complete the read
        add_txn(2'b00, 3'd5, 32'h4, 32'h0, 0, 1, 32'h0BADF00D, 1'b0, 1'b1);
        drain();
        check("rv_with_gnt_rdata", cap_rd, 32'h0BADF00D);
        add_idle(1'b0, 1'b1, 1'b0);
        add_idle(1'b0, 1'b1, 1'b0);

        // store priority over load, reserved load codes
        add_txn(2'b01, 3'd5, 32'h21, 32'h0000005A, 0, 0, 32'h0, 1'b0, 1'b0);
        drain();
        check("prio_be", 32'(cap_be), 32'h2);
        check("prio_adel", adel_cnt, 0);
        add_txn(2'b00, 3'd6, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        add_txn(2'b00, 3'd7, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        drain();

        // timeouts
        add_txn(2'b00, 3'd5, 32'h8, 32'h0, 0, 0, 32'h0, 1'b1, 1'b0);
        drain();
        check("to_load_err", err_cnt, 1);
        check("to_load_rdata", cap_rd_err, 32'h0);
        check("to_load_stall", stall_cnt, 5);
        check("to_load_rdv", rdv_cnt, 0);
        add_txn(2'b11, 3'd0, 32'h20, 32'h0, 9, 0, 32'h0, 1'b0, 1'b0);
        drain();
        check("to_store_err", err_cnt, 1);
        check("to_store_stall", stall_cnt, 5);

        // reset while waiting for the read response
        c = '{default: '0};
        c.ov = 1'b1; c.ld = 3'd5; c.a = 32'h24; c.rw = 32'h11112222; c.clr = 1'b1;
        r = c; r.e_stall = 1'b1; q.push_back(r);
        c.clr = 1'b0;
        r = c; r.e_stall = 1'b1; r.e_req = 1'b1; r.chk_bus = 1'b1;
        r.e_baddr = 32'h24; r.e_be = 4'hF; r.gnt = 1'b1; q.push_back(r);
        r = c; r.e_stall = 1'b1; r.rst = 1'b1; q.push_back(r);
        add_idle(1'b0, 1'b1, 1'b1);
        add_idle(1'b0, 1'b1, 1'b0);
        drain();
        check("rst_resp_rdv", rdv_cnt, 0);
        check("rst_resp_req", req_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
